// File: rtl/pulse_param_regfile.sv
// UART command decoder and parameter register file for the pulse generator.
// Frames are DATA_BYTES data bytes (LSB first) plus one command byte; each frame gets a reply.
module pulse_param_regfile #(
    parameter int NUM_REGS    = 8,
    parameter int DATA_BYTES  = 4,
    parameter logic [NUM_REGS*8*DATA_BYTES-1:0] RESET_VALS = {(NUM_REGS*8*DATA_BYTES){1'b0}},
    parameter int TIMEOUT_CYC = 2010000
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             rx_valid,
    input  logic [7:0]                       rx_byte,
    input  logic                             tx_busy,
    output logic                             tx_start,
    output logic [7:0]                       tx_byte,
    output logic [NUM_REGS*8*DATA_BYTES-1:0] regs_flat,
    output logic [NUM_REGS-1:0]              reg_upd,
    output logic                             frame_err
);

    localparam int DW = 8 * DATA_BYTES;
    localparam int BW = $clog2(DATA_BYTES + 1);
    localparam int IW = $clog2(TIMEOUT_CYC);
    localparam int RW = $clog2(DATA_BYTES + 2);
    localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [BW-1:0] CNT_CMD  = BW'(DATA_BYTES);
    localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT_CYC - 1);
    localparam logic [IW-1:0] IDLE_SAT = {IW{1'b1}};
    localparam logic [7:0]    NREGS8   = 8'(NUM_REGS);
    localparam logic [RW-1:0] LEN_ONE  = RW'(1);
    localparam logic [RW-1:0] LEN_READ = RW'(DATA_BYTES + 1);

    localparam logic [2:0] S_RX      = 3'd0;
    localparam logic [2:0] S_EXEC    = 3'd1;
    localparam logic [2:0] S_TX_LOAD = 3'd2;
    localparam logic [2:0] S_TX_GAP  = 3'd3;
    localparam logic [2:0] S_TX_WAIT = 3'd4;

    // Byte-wise additive checksum used for every reply.
    function automatic logic [7:0] f_csum(input logic [DW-1:0] d);
        logic [7:0] s;
        s = 8'd0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            s = s + d[8*i +: 8];
        end
        return s;
    endfunction

    logic              r_rx_valid_q;
    logic [2:0]        r_state;
    logic [BW-1:0]     r_byte_cnt;
    logic [IW-1:0]     r_idle_cnt;
    logic [DW-1:0]     r_shift;
    logic [7:0]        r_cmd;
    logic [DW-1:0]     r_regs  [NUM_REGS];
    logic [7:0]        r_reply [DATA_BYTES+1];
    logic [RW-1:0]     r_reply_len;
    logic [RW-1:0]     r_tx_idx;
    logic              r_tx_start;
    logic [7:0]        r_tx_byte;
    logic [NUM_REGS-1:0] r_reg_upd;
    logic              r_frame_err;

    logic              w_rx_rise;
    logic [6:0]        w_addr;
    logic              w_is_read;
    logic              w_addr_ok;
    logic [AW-1:0]     w_idx;
    logic [DW-1:0]     w_snap;
    logic              w_wr_en;
    logic              w_drop;
    logic              w_timeout;
    logic              w_bad_addr;

    // Command decode and error sources for the current cycle.
    always_comb begin
        w_rx_rise  = rx_valid & ~r_rx_valid_q;
        w_addr     = r_cmd[6:0];
        w_is_read  = r_cmd[7];
        w_addr_ok  = ({1'b0, w_addr} < NREGS8);
        w_idx      = w_addr[AW-1:0];
        w_snap     = r_regs[w_idx];
        w_wr_en    = (r_state == S_EXEC) && !w_is_read && w_addr_ok;
        w_drop     = w_rx_rise && (r_state != S_RX);
        w_bad_addr = (r_state == S_EXEC) && !w_addr_ok;
        w_timeout  = (r_state == S_RX) && !w_rx_rise &&
                     (r_byte_cnt != {BW{1'b0}}) && (r_idle_cnt == IDLE_MAX);
    end

    // Edge detector on the UART received flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_valid_q <= 1'b0;
        end else begin
            r_rx_valid_q <= rx_valid;
        end
    end

    // Inter-byte idle counter; only runs while a frame is partially received.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle_cnt <= {IW{1'b0}};
        end else if (w_rx_rise || (r_byte_cnt == {BW{1'b0}}) || w_timeout) begin
            r_idle_cnt <= {IW{1'b0}};
        end else if (r_idle_cnt != IDLE_SAT) begin
            r_idle_cnt <= r_idle_cnt + IW'(1);
        end
    end

    // Parameter registers and their update strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= RESET_VALS[i*DW +: DW];
            end
            r_reg_upd <= {NUM_REGS{1'b0}};
        end else begin
            r_reg_upd <= {NUM_REGS{1'b0}};
            if (w_wr_en) begin
                r_regs[w_idx]    <= r_shift;
                r_reg_upd[w_idx] <= 1'b1;
            end
        end
    end

    // Single pulse per cycle regardless of how many error sources fire together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_drop | w_timeout | w_bad_addr;
        end
    end

    // Frame collection, command execution and reply sequencing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_RX;
            r_byte_cnt  <= {BW{1'b0}};
            r_shift     <= {DW{1'b0}};
            r_cmd       <= 8'd0;
            r_reply_len <= {RW{1'b0}};
            r_tx_idx    <= {RW{1'b0}};
            r_tx_start  <= 1'b0;
            r_tx_byte   <= 8'd0;
            for (int i = 0; i <= DATA_BYTES; i++) begin
                r_reply[i] <= 8'd0;
            end
        end else begin
            r_tx_start <= 1'b0;
            case (r_state)
                S_RX: begin
                    if (w_rx_rise) begin
                        if (r_byte_cnt == CNT_CMD) begin
                            r_cmd      <= rx_byte;
                            r_byte_cnt <= {BW{1'b0}};
                            r_state    <= S_EXEC;
                        end else begin
                            r_shift[{r_byte_cnt, 3'b000} +: 8] <= rx_byte;
                            r_byte_cnt <= r_byte_cnt + BW'(1);
                        end
                    end else if (w_timeout) begin
                        r_byte_cnt <= {BW{1'b0}};
                        r_shift    <= {DW{1'b0}};
                    end
                end
                S_EXEC: begin
                    if (w_is_read && w_addr_ok) begin
                        for (int i = 0; i < DATA_BYTES; i++) begin
                            r_reply[i] <= w_snap[8*i +: 8];
                        end
                        r_reply[DATA_BYTES] <= f_csum(w_snap);
                        r_reply_len         <= LEN_READ;
                    end else begin
                        r_reply[0]  <= w_addr_ok ? f_csum(r_shift) : (f_csum(r_shift) ^ 8'hFF);
                        r_reply_len <= LEN_ONE;
                    end
                    r_tx_idx <= {RW{1'b0}};
                    r_state  <= S_TX_LOAD;
                end
                S_TX_LOAD: begin
                    if (!tx_busy) begin
                        r_tx_byte  <= r_reply[r_tx_idx];
                        r_tx_start <= 1'b1;
                        r_tx_idx   <= r_tx_idx + RW'(1);
                        r_state    <= S_TX_GAP;
                    end
                end
                // The UART raises busy a cycle after the request, so its level is ignored here.
                S_TX_GAP: begin
                    r_state <= S_TX_WAIT;
                end
                S_TX_WAIT: begin
                    if (!tx_busy) begin
                        r_state <= (r_tx_idx < r_reply_len) ? S_TX_LOAD : S_RX;
                    end
                end
                default: begin
                    r_state <= S_RX;
                end
            endcase
        end
    end

    generate
        for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
            assign regs_flat[g*DW +: DW] = r_regs[g];
        end
    endgenerate

    assign tx_start  = r_tx_start;
    assign tx_byte   = r_tx_byte;
    assign reg_upd   = r_reg_upd;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_pulse_param_regfile.sv
// Scoreboard bench for pulse_param_regfile: expected replies and register updates are queued
// by the stimulus and consumed by a monitor watching tx_start and reg_upd.
module tb_pulse_param_regfile;

    localparam int NR = 8;
    localparam int DW = 32;
    localparam int TO = 200;
    localparam logic [NR*DW-1:0] RV = {32'hA5A5_0007, 32'hA5A5_0006, 32'hA5A5_0005, 32'hA5A5_0004,
                                       32'hA5A5_0003, 32'hA5A5_0002, 32'hA5A5_0001, 32'hA5A5_0000};

    typedef struct {
        logic [NR-1:0] mask;
        int            idx;
        logic [DW-1:0] val;
    } upd_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            rx_valid;
    logic [7:0]      rx_byte;
    logic            tx_busy;
    logic            tx_start;
    logic [7:0]      tx_byte;
    logic [NR*DW-1:0] regs_flat;
    logic [NR-1:0]   reg_upd;
    logic            frame_err;

    logic [7:0]  tx_exp[$];
    upd_t        upd_exp[$];
    logic [DW-1:0] model [NR];
    int checks = 0, errors = 0, err_seen = 0, exp_err = 0;
    int cyc = 0, last_cmd_cyc = 0, busy_cnt = 0;

    pulse_param_regfile #(
        .NUM_REGS(NR), .DATA_BYTES(4), .RESET_VALS(RV), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_byte(rx_byte), .tx_busy(tx_busy),
        .tx_start(tx_start), .tx_byte(tx_byte), .regs_flat(regs_flat), .reg_upd(reg_upd),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Cycle counter and a UART model that goes busy one cycle after each request.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) busy_cnt <= 0;
        else if (tx_start) busy_cnt <= 10;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0);

    task automatic chk(input string name, input logic [NR*DW-1:0] act, input logic [NR*DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [NR*DW-1:0] model_flat();
        logic [NR*DW-1:0] f;
        for (int i = 0; i < NR; i++) f[i*DW +: DW] = model[i];
        return f;
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents a reply byte or an update strobe.
    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_start) begin
                checks++;
                if (tx_exp.size() == 0) begin
                    errors++;
                    $display("FAIL tx_unexpected: got %h with nothing expected", tx_byte);
                end else begin
                    logic [7:0] e;
                    e = tx_exp.pop_front();
                    if (tx_byte !== e) begin
                        errors++;
                        $display("FAIL tx_byte: got %h expected %h", tx_byte, e);
                    end
                end
            end
            if (reg_upd != '0) begin
                if (upd_exp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL upd_unexpected: got %h with nothing expected", reg_upd);
                end else begin
                    upd_t u;
                    u = upd_exp.pop_front();
                    chk("reg_upd_mask", NR*DW'(reg_upd), NR*DW'(u.mask));
                    chk("reg_upd_value", NR*DW'(regs_flat[u.idx*DW +: DW]), NR*DW'(u.val));
                    chk("reg_upd_latency", NR*DW'(cyc - last_cmd_cyc), NR*DW'(2));
                end
            end
            if (frame_err) err_seen++;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int hold, input bit is_cmd);
        @(negedge clk);
        rx_byte = b;
        rx_valid = 1'b1;
        if (is_cmd) last_cmd_cyc = cyc;
        repeat (hold) @(negedge clk);
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_frame(input logic [31:0] data, input logic [7:0] cmd, input int hold);
        for (int i = 0; i < 4; i++) send_byte(data[8*i +: 8], hold, 1'b0);
        send_byte(cmd, hold, 1'b1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000 && (tx_exp.size() != 0 || upd_exp.size() != 0); i++) @(negedge clk);
        if (tx_exp.size() != 0 || upd_exp.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: %0d replies and %0d updates still pending, 0 required",
                     tx_exp.size(), upd_exp.size());
            tx_exp.delete();
            upd_exp.delete();
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic wait_tx_left(input int left);
        for (int i = 0; i < 3000 && tx_exp.size() > left; i++) @(negedge clk);
        if (tx_exp.size() > left) begin
            checks++;
            errors++;
            $display("FAIL wait_tx: %0d replies pending, at most %0d required", tx_exp.size(), left);
        end
    endtask

    task automatic write_reg(input int idx, input logic [31:0] val, input logic [7:0] cs, input int hold);
        upd_t u;
        u.mask = NR'(1) << idx;
        u.idx  = idx;
        u.val  = val;
        upd_exp.push_back(u);
        tx_exp.push_back(cs);
        model[idx] = val;
        send_frame(val, 8'(idx), hold);
        wait_idle();
    endtask

    task automatic push_read(input logic [39:0] rep);
        for (int i = 0; i < 5; i++) tx_exp.push_back(rep[8*i +: 8]);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rx_valid = 1'b0;
        tx_exp.delete();
        upd_exp.delete();
        for (int i = 0; i < NR; i++) model[i] = RV[i*DW +: DW];
        repeat (3) @(negedge clk);
        chk("reset_tx_start", NR*DW'(tx_start), NR*DW'(0));
        chk("reset_regs", regs_flat, model_flat());
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        rx_valid = 1'b0;
        rx_byte = 8'd0;
        for (int i = 0; i < NR; i++) model[i] = RV[i*DW +: DW];
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("init_tx_start", NR*DW'(tx_start), NR*DW'(0));
        chk("init_tx_byte", NR*DW'(tx_byte), NR*DW'(0));
        chk("init_reg_upd", NR*DW'(reg_upd), NR*DW'(0));
        chk("init_frame_err", NR*DW'(frame_err), NR*DW'(0));
        chk("init_regs", regs_flat, model_flat());

        // Plain write and read-back, then write/read of the top register.
        write_reg(0, 32'h0000_0010, 8'h10, 2);
        push_read(40'h10_00_00_00_10);
        send_frame(32'h0, 8'h80, 2);
        wait_idle();
        write_reg(7, 32'hDEAD_BEEF, 8'h38, 2);
        push_read(40'h38_DE_AD_BE_EF);
        send_frame(32'h0, 8'h87, 2);
        wait_idle();

        // First out-of-range address.
        tx_exp.push_back(8'hF5);
        exp_err++;
        send_frame(32'h0403_0201, 8'h08, 2);
        wait_idle();
        chk("bad_addr_err", NR*DW'(err_seen), NR*DW'(exp_err));
        chk("bad_addr_regs", regs_flat, model_flat());

        // Partial frame left idle: no error just before the limit, one error after it.
        send_byte(8'h11, 2, 1'b0);
        send_byte(8'h22, 2, 1'b0);
        repeat (TO - 20) @(negedge clk);
        chk("timeout_early", NR*DW'(err_seen), NR*DW'(exp_err));
        repeat (40) @(negedge clk);
        exp_err++;
        chk("timeout_err", NR*DW'(err_seen), NR*DW'(exp_err));
        write_reg(1, 32'h00C0_FFEE, 8'hAD, 2);

        // Long rx_valid assertions count one byte each.
        write_reg(2, 32'h1234_5678, 8'h14, 50);

        // A byte arriving during a reply is dropped and the reply completes untouched.
        push_read(40'h14_12_34_56_78);
        send_frame(32'h0, 8'h82, 2);
        wait_tx_left(4);
        exp_err++;
        send_byte(8'h55, 2, 1'b0);
        wait_idle();
        chk("inject_err", NR*DW'(err_seen), NR*DW'(exp_err));
        push_read(40'hAD_00_C0_FF_EE);
        send_frame(32'h0, 8'h81, 2);
        wait_idle();
        chk("regs_before_reset", regs_flat, model_flat());

        // Reset in the middle of the third byte.
        send_byte(8'hAA, 2, 1'b0);
        send_byte(8'hBB, 2, 1'b0);
        @(negedge clk);
        rx_byte = 8'hCC;
        rx_valid = 1'b1;
        repeat (3) @(negedge clk);
        do_reset();

        // Reset in the middle of a read reply.
        write_reg(5, 32'h0BAD_F00D, 8'hB5, 2);
        push_read(40'hB5_0B_AD_F0_0D);
        send_frame(32'h0, 8'h85, 2);
        wait_tx_left(3);
        do_reset();

        write_reg(3, 32'h1122_3344, 8'hAA, 2);
        push_read(40'h4A_A5_A5_00_00);
        send_frame(32'h0, 8'h80, 2);
        wait_idle();
        chk("final_err", NR*DW'(err_seen), NR*DW'(exp_err));
        chk("final_regs", regs_flat, model_flat());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
